relay_dispense_ctrl: RTL and testbench

Parametrised relay dispense controller for the fuel pumping path. It takes N preset-select buttons and drives the pump relay. Each dispense ends after a per-preset time (time mode) or after a per-preset count of flow-meter pulses (flow mode). It adds stop/abort, flow-loss timeout fault, and busy/done/selected-preset status for the display and measurement logic.

---
 rtl/relay_dispense_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_relay_dispense_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_dispense_ctrl.sv
// rtl/relay_dispense_ctrl.sv - preset-driven pump relay controller with time/flow termination
module relay_dispense_ctrl #(
    parameter int                          CLK_HZ          = 1_000_000,
    parameter int                          NUM_PRESETS     = 3,
    parameter logic [32*NUM_PRESETS-1:0]   PRESET_MS       = {32'd15000, 32'd7000, 32'd3000},
    parameter logic [32*NUM_PRESETS-1:0]   PRESET_PULSES   = {32'd1500, 32'd700, 32'd300},
    parameter int                          FLOW_TIMEOUT_MS = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PRESETS-1:0] btn,
    input  logic                   btn_stop,
    input  logic                   flow_pulse,
    input  logic                   mode,
    output logic                   relay_out,
    output logic                   busy,
    output logic [2:0]             sel,
    output logic                   done,
    output logic                   aborted,
    output logic                   fault
);

    localparam int              DIV       = CLK_HZ / 1000;
    localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
    localparam logic [31:0]     TIMEOUT   = 32'(FLOW_TIMEOUT_MS);
    localparam int              NI        = NUM_PRESETS + 2;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t            state, state_n;
    logic [NI-1:0]     raw_in, s1, s2, prev, rise;
    logic [NUM_PRESETS-1:0] btn_rise;
    logic              stop_rise, flow_rise;

    logic              mode_lat, mode_lat_n;
    logic [31:0]       target, target_n;
    logic [PW-1:0]     presc, presc_n;
    logic [31:0]       ms_cnt, ms_n;
    logic [31:0]       pulse_cnt, pulse_n;
    logic [2:0]        sel_n;
    logic              relay_n, busy_n, done_n, aborted_n, fault_n;

    logic              hit, tick, complete, timeout;
    logic [2:0]        idx;
    logic [31:0]       new_target;

    assign raw_in    = {flow_pulse, btn_stop, btn};
    assign rise      = s2 & ~prev;
    assign btn_rise  = rise[NUM_PRESETS-1:0];
    assign stop_rise = rise[NUM_PRESETS];
    assign flow_rise = rise[NUM_PRESETS+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= raw_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            mode_lat  <= 1'b0;
            target    <= '0;
            presc     <= '0;
            ms_cnt    <= '0;
            pulse_cnt <= '0;
            relay_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            mode_lat  <= mode_lat_n;
            target    <= target_n;
            presc     <= presc_n;
            ms_cnt    <= ms_n;
            pulse_cnt <= pulse_n;
            relay_out <= relay_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
            fault     <= fault_n;
        end
    end

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        mode_lat_n = mode_lat;
        target_n   = target;
        presc_n    = presc;
        ms_n       = ms_cnt;
        pulse_n    = pulse_cnt;
        relay_n    = relay_out;
        busy_n     = busy;
        done_n     = 1'b0;
        aborted_n  = 1'b0;
        fault_n    = fault;

        // Descending scan so the lowest simultaneous index is the one kept.
        hit        = 1'b0;
        idx        = '0;
        new_target = '0;
        for (int i = NUM_PRESETS - 1; i >= 0; i--) begin
            if (btn_rise[i]) begin
                hit        = 1'b1;
                idx        = 3'(i);
                new_target = mode ? PRESET_PULSES[32*i +: 32] : PRESET_MS[32*i +: 32];
            end
        end

        tick     = (presc == PRESC_MAX);
        complete = mode_lat ? (pulse_cnt == target)
                            : (tick && (ms_cnt == target - 32'd1));
        timeout  = mode_lat && !flow_rise && tick && (ms_cnt == TIMEOUT - 32'd1);

        case (state)
            IDLE: begin
                if (hit) begin
                    sel_n = idx;
                    if (new_target == 32'd0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n    = RUN;
                        mode_lat_n = mode;
                        target_n   = new_target;
                        presc_n    = '0;
                        ms_n       = '0;
                        pulse_n    = '0;
                        relay_n    = 1'b1;
                        busy_n     = 1'b1;
                    end
                end
            end
            RUN: begin
                // In flow mode the ms counter measures time since the last pulse.
                if (mode_lat && flow_rise) begin
                    pulse_n = pulse_cnt + 32'd1;
                    presc_n = '0;
                    ms_n    = '0;
                end else if (tick) begin
                    presc_n = '0;
                    ms_n    = ms_cnt + 32'd1;
                end else begin
                    presc_n = presc + PW'(1);
                end

                if (complete) begin
                    state_n = IDLE;
                    relay_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (timeout) begin
                    state_n = FAULT;
                    relay_n = 1'b0;
                    busy_n  = 1'b0;
                    fault_n = 1'b1;
                end else if (stop_rise) begin
                    state_n   = IDLE;
                    relay_n   = 1'b0;
                    busy_n    = 1'b0;
                    aborted_n = 1'b1;
                end
            end
            FAULT: begin
                relay_n = 1'b0;
                busy_n  = 1'b0;
                if (stop_rise) begin
                    fault_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                relay_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_relay_dispense_ctrl.sv
// tb/tb_relay_dispense_ctrl.sv - directed self-checking bench for relay_dispense_ctrl
module tb_relay_dispense_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] btn;
    logic       btn_stop;
    logic       flow_pulse;
    logic       mode;
    logic       relay_out;
    logic       busy;
    logic [2:0] sel;
    logic       done;
    logic       aborted;
    logic       fault;

    int errors = 0;
    int checks = 0;

    relay_dispense_ctrl #(
        .CLK_HZ          (10_000),
        .NUM_PRESETS     (3),
        .PRESET_MS       ({32'd300, 32'd70, 32'd30}),
        .PRESET_PULSES   ({32'd0, 32'd5, 32'd10}),
        .FLOW_TIMEOUT_MS (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .btn_stop   (btn_stop),
        .flow_pulse (flow_pulse),
        .mode       (mode),
        .relay_out  (relay_out),
        .busy       (busy),
        .sel        (sel),
        .done       (done),
        .aborted    (aborted),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_sel(input string tag, input logic [2:0] exp);
        checks++;
        assert (sel === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, sel, exp);
        end
    endtask

    // Drive a button pattern for 5 cycles; the relay must rise on the 3rd sampling edge.
    // Returns at the negedge two cycles after the rising edge that raised the relay.
    task automatic press(input logic [2:0] m, input string tag);
        btn = m;
        step(2);
        chk({tag, "_pre_rise"}, relay_out, 1'b0);
        step(1);
        chk({tag, "_rise"}, relay_out, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        step(2);
        btn = '0;
    endtask

    initial begin
        rst        = 1'b1;
        btn        = '0;
        btn_stop   = 1'b0;
        flow_pulse = 1'b0;
        mode       = 1'b0;
        step(3);
        chk("rst_relay", relay_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_aborted", aborted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk_sel("rst_sel", 3'd0);
        rst = 1'b0;
        step(3);

        // Time mode preset 0: 30 ms at 10 cycles/ms = 300 cycles.
        press(3'b001, "t1");
        chk_sel("t1_sel", 3'd0);
        step(297);
        chk("t1_last_high", relay_out, 1'b1);
        chk("t1_no_early_done", done, 1'b0);
        step(1);
        chk("t1_fall", relay_out, 1'b0);
        chk("t1_done", done, 1'b1);
        chk("t1_busy_low", busy, 1'b0);
        step(1);
        chk("t1_done_once", done, 1'b0);
        step(5);

        // Preset 2 (3000 cycles) with a btn[1] press mid-run that must be ignored.
        press(3'b100, "t2");
        step(100);
        btn = 3'b010;
        step(5);
        btn = '0;
        step(2892);
        chk("t2_last_high", relay_out, 1'b1);
        chk_sel("t2_sel", 3'd2);
        step(1);
        chk("t2_fall", relay_out, 1'b0);
        chk("t2_done", done, 1'b1);
        step(5);

        // btn[1] and btn[2] together: lowest index wins, 700 cycles.
        press(3'b110, "t2b");
        chk_sel("t2b_sel", 3'd1);
        step(697);
        chk("t2b_last_high", relay_out, 1'b1);
        step(1);
        chk("t2b_fall", relay_out, 1'b0);
        chk("t2b_done", done, 1'b1);
        step(5);

        // Flow mode preset 1: 5 pulses, 40 cycles apart.
        mode = 1'b1;
        press(3'b010, "t3");
        mode = 1'b0;
        step(10);
        for (int i = 0; i < 4; i++) begin
            flow_pulse = 1'b1;
            step(4);
            flow_pulse = 1'b0;
            step(36);
        end
        chk("t3_after4_high", relay_out, 1'b1);
        flow_pulse = 1'b1;
        step(3);
        chk("t3_count_reached_high", relay_out, 1'b1);
        chk("t3_no_early_done", done, 1'b0);
        step(1);
        flow_pulse = 1'b0;
        chk("t3_fall", relay_out, 1'b0);
        chk("t3_done", done, 1'b1);
        step(1);
        chk("t3_done_once", done, 1'b0);
        chk("t3_busy_low", busy, 1'b0);
        step(5);

        // Flow mode preset 0 (10 pulses), only 2 arrive: timeout after 20 ms.
        mode = 1'b1;
        press(3'b001, "t4");
        mode = 1'b0;
        step(10);
        flow_pulse = 1'b1;
        step(4);
        flow_pulse = 1'b0;
        step(36);
        flow_pulse = 1'b1;
        step(4);
        flow_pulse = 1'b0;
        step(198);
        chk("t4_pre_timeout_relay", relay_out, 1'b1);
        chk("t4_pre_timeout_fault", fault, 1'b0);
        step(1);
        chk("t4_timeout_relay", relay_out, 1'b0);
        chk("t4_timeout_fault", fault, 1'b1);
        chk("t4_timeout_busy", busy, 1'b0);
        chk("t4_timeout_no_done", done, 1'b0);
        btn = 3'b001;
        step(5);
        btn = '0;
        step(3);
        chk("t4_btn_ignored_relay", relay_out, 1'b0);
        chk("t4_fault_sticky", fault, 1'b1);
        btn_stop = 1'b1;
        step(2);
        chk("t4_fault_before_clear", fault, 1'b1);
        step(1);
        chk("t4_fault_cleared", fault, 1'b0);
        chk("t4_clear_no_abort", aborted, 1'b0);
        step(2);
        btn_stop = 1'b0;
        step(5);

        // Time mode preset 2, stop at cycle 1000.
        press(3'b100, "t5");
        step(998);
        btn_stop = 1'b1;
        step(2);
        chk("t5_pre_stop_relay", relay_out, 1'b1);
        step(1);
        chk("t5_stop_relay", relay_out, 1'b0);
        chk("t5_aborted", aborted, 1'b1);
        chk("t5_no_done", done, 1'b0);
        step(1);
        chk("t5_aborted_once", aborted, 1'b0);
        btn_stop = 1'b0;
        step(5);

        // Reset mid-dispense clears everything asynchronously.
        press(3'b100, "t5r");
        step(50);
        rst = 1'b1;
        #1;
        chk("t5r_relay", relay_out, 1'b0);
        chk("t5r_busy", busy, 1'b0);
        chk("t5r_done", done, 1'b0);
        chk("t5r_aborted", aborted, 1'b0);
        chk_sel("t5r_sel", 3'd0);
        step(2);
        rst = 1'b0;
        step(5);
        chk("t5r_stays_off", relay_out, 1'b0);

        // Zero target: preset 2 in flow mode has 0 pulses.
        mode = 1'b1;
        btn = 3'b100;
        step(2);
        chk("t6_pre_done", done, 1'b0);
        step(1);
        chk("t6_done", done, 1'b1);
        chk("t6_relay", relay_out, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk_sel("t6_sel", 3'd2);
        step(1);
        chk("t6_done_once", done, 1'b0);
        step(3);
        btn = '0;
        mode = 1'b0;
        step(20);
        chk("t6_relay_never", relay_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
